// File: rtl/clock_pkg.sv
// Shared sizes, FSM state type and frame helpers for the SPI clock-frame receiver.
package clock_pkg;

    localparam int unsigned N_POS      = 12;
    localparam int unsigned FRAME_BITS = 96;
    localparam int unsigned BYTE_BITS  = 8;
    localparam int unsigned NIB_BITS   = 4;
    localparam int unsigned DIGIT_BITS = N_POS * NIB_BITS;
    localparam int unsigned CNT_BITS   = 7;

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(FRAME_BITS);
    localparam logic [CNT_BITS-1:0] CNT_SAT  = CNT_BITS'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_e;

    // Identity clock: position k+1 shows k+1, position 12 in the MSBs.
    localparam logic [DIGIT_BITS-1:0] RESET_DIGITS = 48'hCBA9_8765_4321;

    // Byte k (position k+1) was shifted in first, so it sits at the top of the register.
    function automatic logic [BYTE_BITS-1:0] frame_byte(input logic [FRAME_BITS-1:0] sr,
                                                        input int unsigned k);
        return sr[FRAME_BITS - 1 - k * BYTE_BITS -: BYTE_BITS];
    endfunction

    // True when every byte is 0000_dddd, dddd in 1..12, and no value repeats.
    function automatic logic frame_legal(input logic [FRAME_BITS-1:0] sr);
        logic [N_POS-1:0]     seen;
        logic                 ok;
        logic [BYTE_BITS-1:0] b;
        logic [NIB_BITS-1:0]  v;
        seen = '0;
        ok   = 1'b1;
        for (int unsigned k = 0; k < N_POS; k++) begin
            b = frame_byte(sr, k);
            v = b[NIB_BITS-1:0];
            if (b[BYTE_BITS-1:NIB_BITS] != 4'd0) begin
                ok = 1'b0;
            end
            if ((v == 4'd0) || (v > 4'd12)) begin
                ok = 1'b0;
            end else begin
                seen[4'(v - 4'd1)] = 1'b1;
            end
        end
        return ok && (seen == 12'hFFF);
    endfunction

    // Packs the lower nibble of each byte into the digit bus, position 1 in the LSBs.
    function automatic logic [DIGIT_BITS-1:0] frame_digits(input logic [FRAME_BITS-1:0] sr);
        logic [DIGIT_BITS-1:0] d;
        logic [BYTE_BITS-1:0]  b;
        d = '0;
        for (int unsigned k = 0; k < N_POS; k++) begin
            b = frame_byte(sr, k);
            d[k * NIB_BITS +: NIB_BITS] = b[NIB_BITS-1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/clock_frame_rx_sync_edge.sv
// Two-flop synchroniser with registered rise/fall detect; reset level chosen per pin.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Synchronise the pin, keep the previous synchronised value and flag its edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= rst_val;
            s2_q   <= rst_val;
            prev_q <= rst_val;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
            fall_q <= ~s2_q & prev_q;
        end
    end

    assign sync = s2_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/clock_frame_rx.sv
// SPI frame receiver: assembles twelve position bytes and commits only legal permutations.
module clock_frame_rx
    import clock_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  cs_n,
    output logic [DIGIT_BITS-1:0] digits,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    logic sck_sync, sck_rise, sck_fall;
    logic sdi_sync, sdi_rise, sdi_fall;
    logic cs_sync,  cs_rise,  cs_fall;

    sync_edge u_sync_sck (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b0),
        .d       (sck),
        .sync    (sck_sync),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    sync_edge u_sync_sdi (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b0),
        .d       (sdi),
        .sync    (sdi_sync),
        .rise    (sdi_rise),
        .fall    (sdi_fall)
    );

    sync_edge u_sync_cs (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b1),
        .d       (cs_n),
        .sync    (cs_sync),
        .rise    (cs_rise),
        .fall    (cs_fall)
    );

    // Only the edges of sck/cs_n and the level of sdi matter here.
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_sync, sck_fall, sdi_rise, sdi_fall, cs_sync};

    state_e                state_q;
    logic [FRAME_BITS-1:0] sr_q,  sr_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  ovr_q;
    logic [DIGIT_BITS-1:0] digits_q;
    logic                  valid_q;
    logic                  err_q;
    logic                  busy_q;
    logic                  frame_pass_c;

    // Next shift-register/counter values for a received bit, and the frame verdict.
    always_comb begin
        sr_d         = {sr_q[FRAME_BITS-2:0], sdi_sync};
        cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_BITS'(1);
        frame_pass_c = (cnt_q == CNT_FULL) && !ovr_q && frame_legal(sr_q);
    end

    // Receive FSM with registered digit bus and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            digits_q <= RESET_DIGITS;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= RECV;
                        sr_q    <= '0;
                        cnt_q   <= '0;
                        ovr_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RECV: begin
                    if (sck_rise) begin
                        sr_q  <= sr_d;
                        cnt_q <= cnt_d;
                        if (cnt_q == CNT_FULL) begin
                            ovr_q <= 1'b1;
                        end
                    end
                    if (cs_rise) begin
                        // An empty select (no bit at all, counting a coincident one) is dropped silently.
                        if ((cnt_q == '0) && !sck_rise) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (frame_pass_c) begin
                        digits_q <= frame_digits(sr_q);
                        valid_q  <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign digits      = digits_q;
    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_clock_frame_rx.sv
// Self-checking bench for clock_frame_rx: directed frames plus randomized frames vs a byte-level model.
module tb_clock_frame_rx;

    localparam logic [47:0] RST_DG = 48'hCBA9_8765_4321;

    logic        clk = 1'b0;
    logic        reset;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic [47:0] digits;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    clock_frame_rx dut (
        .clk         (clk),
        .reset       (reset),
        .sck         (sck),
        .sdi         (sdi),
        .cs_n        (cs_n),
        .digits      (digits),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    bit          txq[$];
    logic [7:0]  fb[12];
    logic [47:0] exp_dg;
    logic [47:0] mdg;
    bit          mpass;

    int          ob_v, ob_e, ob_vcyc, ob_both;
    logic        ob_busy4, ob_busy5;
    int          dig_glitch = 0;
    logic [47:0] prev_dg;

    // Digits may only move on a frame_valid cycle or under reset.
    always @(posedge clk) begin
        #1;
        if (reset !== 1'b0) begin
            prev_dg = digits;
        end else begin
            if (digits !== prev_dg && frame_valid !== 1'b1) dig_glitch++;
            prev_dg = digits;
        end
    end

    task automatic fill_q();
        txq.delete();
        for (int k = 0; k < 12; k++)
            for (int j = 7; j >= 0; j--) txq.push_back(fb[k][j]);
    endtask

    task automatic make_perm();
        logic [7:0] t;
        int         j;
        for (int k = 0; k < 12; k++) fb[k] = 8'(k + 1);
        for (int k = 11; k > 0; k--) begin
            j     = int'($urandom_range(0, k));
            t     = fb[k];
            fb[k] = fb[j];
            fb[j] = t;
        end
    endtask

    // Reference: 96 bits, twelve bytes each holding 1..12, every value exactly once.
    function automatic bit model_pass(output logic [47:0] dg);
        int cnt[16];
        int v;
        bit ok;
        dg = '0;
        for (int i = 0; i < 16; i++) cnt[i] = 0;
        ok = (txq.size() == 96);
        if (ok) begin
            for (int k = 0; k < 12; k++) begin
                v = 0;
                for (int j = 0; j < 8; j++) v = v * 2 + int'(txq[8 * k + j]);
                if (v < 1 || v > 12) ok = 0;
                else begin
                    cnt[v]++;
                    dg[4 * k +: 4] = 4'(v);
                end
            end
            for (int i = 1; i <= 12; i++) if (cnt[i] != 1) ok = 0;
        end
        return ok;
    endfunction

    task automatic drive_bit(input bit b);
        sdi = b;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    // Sends txq inside one cs_n select and records the response window after cs_n rises.
    task automatic run_frame();
        ob_v = 0; ob_e = 0; ob_vcyc = 0; ob_both = 0; ob_busy4 = 1'b0; ob_busy5 = 1'b1;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        foreach (txq[i]) drive_bit(txq[i]);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1) begin ob_v++; ob_vcyc = c; end
            if (frame_err === 1'b1) ob_e++;
            if (frame_valid === 1'b1 && frame_err === 1'b1) ob_both++;
            if (c == 4) ob_busy4 = busy;
            if (c == 5) ob_busy5 = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_dg = RST_DG;
        repeat (4) @(negedge clk);
        checks++; if (digits !== RST_DG) begin failures++; $display("FAIL reset_digits: got %h expected %h", digits, RST_DG); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", frame_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_legal_desc();
        for (int k = 0; k < 12; k++) fb[k] = 8'(12 - k);
        fill_q();
        run_frame();
        exp_dg = 48'h1234_5678_9ABC;
        checks++; if (ob_v != 1) begin failures++; $display("FAIL desc_valid_count: got %0d expected 1", ob_v); end
        checks++; if (ob_e != 0) begin failures++; $display("FAIL desc_err_count: got %0d expected 0", ob_e); end
        checks++; if (ob_vcyc != 5) begin failures++; $display("FAIL desc_latency: got %0d expected 5", ob_vcyc); end
        checks++; if (ob_busy4 !== 1'b1 || ob_busy5 !== 1'b0) begin failures++; $display("FAIL desc_busy: got %b%b expected 10", ob_busy4, ob_busy5); end
        checks++; if (digits !== exp_dg) begin failures++; $display("FAIL desc_digits: got %h expected %h", digits, exp_dg); end
    endtask

    task automatic test_duplicate();
        for (int k = 0; k < 12; k++) fb[k] = 8'(k + 1);
        fb[4] = 8'd3;
        fb[6] = 8'd5;
        fill_q();
        run_frame();
        checks++; if (ob_e != 1 || ob_v != 0) begin failures++; $display("FAIL dup_pulses: got v=%0d e=%0d expected v=0 e=1", ob_v, ob_e); end
        checks++; if (ob_both != 0) begin failures++; $display("FAIL dup_overlap: got %0d expected 0", ob_both); end
        checks++; if (digits !== exp_dg) begin failures++; $display("FAIL dup_digits: got %h expected %h", digits, exp_dg); end
    endtask

    task automatic test_length();
        make_perm(); fill_q(); void'(txq.pop_back());
        run_frame();
        checks++; if (ob_e != 1 || ob_v != 0) begin failures++; $display("FAIL short_pulses: got v=%0d e=%0d expected v=0 e=1", ob_v, ob_e); end
        checks++; if (digits !== exp_dg) begin failures++; $display("FAIL short_digits: got %h expected %h", digits, exp_dg); end
        make_perm(); fill_q(); txq.push_back(1'b0);
        run_frame();
        checks++; if (ob_e != 1 || ob_v != 0) begin failures++; $display("FAIL long_pulses: got v=%0d e=%0d expected v=0 e=1", ob_v, ob_e); end
        checks++; if (digits !== exp_dg) begin failures++; $display("FAIL long_digits: got %h expected %h", digits, exp_dg); end
        txq.delete();
        run_frame();
        checks++; if (ob_e != 0 || ob_v != 0) begin failures++; $display("FAIL empty_pulses: got v=%0d e=%0d expected v=0 e=0", ob_v, ob_e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy: got %b expected 0", busy); end
    endtask

    task automatic test_bad_values();
        logic [7:0] bad[3];
        int         p;
        bad[0] = 8'h21; bad[1] = 8'h00; bad[2] = 8'h0D;
        for (int i = 0; i < 3; i++) begin
            make_perm();
            p     = int'($urandom_range(0, 11));
            fb[p] = bad[i];
            fill_q();
            run_frame();
            checks++; if (ob_e != 1 || ob_v != 0) begin failures++; $display("FAIL badval_pulses[%0d]: got v=%0d e=%0d expected v=0 e=1", i, ob_v, ob_e); end
            checks++; if (digits !== exp_dg) begin failures++; $display("FAIL badval_digits[%0d]: got %h expected %h", i, digits, exp_dg); end
        end
    endtask

    task automatic test_reset_midframe();
        make_perm(); fill_q();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 40; i++) drive_bit(txq[i]);
        reset = 1'b1;
        #1;
        checks++; if (digits !== RST_DG) begin failures++; $display("FAIL midreset_digits: got %h expected %h", digits, RST_DG); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_dg = RST_DG;
        repeat (8) @(negedge clk);
        checks++; if (digits !== RST_DG || frame_valid !== 1'b0) begin failures++; $display("FAIL midreset_hold: got %h/%b expected %h/0", digits, frame_valid, RST_DG); end
        make_perm(); fill_q();
        mpass = model_pass(mdg);
        run_frame();
        if (mpass) exp_dg = mdg;
        checks++; if (ob_v != 1 || ob_e != 0) begin failures++; $display("FAIL postreset_pulses: got v=%0d e=%0d expected v=1 e=0", ob_v, ob_e); end
        checks++; if (digits !== exp_dg) begin failures++; $display("FAIL postreset_digits: got %h expected %h", digits, exp_dg); end
    endtask

    task automatic test_random();
        int kind, a, b;
        for (int it = 0; it < 12; it++) begin
            make_perm();
            kind = int'($urandom_range(0, 5));
            a    = int'($urandom_range(0, 11));
            b    = (a + 1 + int'($urandom_range(0, 10))) % 12;
            case (kind)
                2: fb[a] = fb[b];
                3: fb[a] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(13, 15));
                4: fb[a] = fb[a] | 8'(8'h10 << $urandom_range(0, 3));
                default: ;
            endcase
            fill_q();
            if (kind == 5) begin
                if ($urandom_range(0, 1) == 0) void'(txq.pop_back());
                else txq.push_back(1'($urandom_range(0, 1)));
            end
            mpass = model_pass(mdg);
            run_frame();
            if (mpass) exp_dg = mdg;
            checks++; if (ob_v != (mpass ? 1 : 0) || ob_e != (mpass ? 0 : 1)) begin failures++; $display("FAIL rand_pulses[%0d]: got v=%0d e=%0d expected pass=%0d", it, ob_v, ob_e, mpass); end
            checks++; if (digits !== exp_dg) begin failures++; $display("FAIL rand_digits[%0d]: got %h expected %h", it, digits, exp_dg); end
            checks++; if (ob_both != 0) begin failures++; $display("FAIL rand_overlap[%0d]: got %0d expected 0", it, ob_both); end
        end
    endtask

    task automatic test_digit_stability();
        checks++; if (dig_glitch != 0) begin failures++; $display("FAIL digit_stability: got %0d stray changes expected 0", dig_glitch); end
    endtask

    initial begin
        test_reset();
        test_legal_desc();
        test_duplicate();
        test_length();
        test_bad_values();
        test_reset_midframe();
        test_random();
        test_digit_stability();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
